// File: rtl/moore_fsm_nol_pkg.sv
// Shared state type and detect-state constant for the 1101 sequence detector.
package moore_fsm_nol_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  localparam state_e DETECT_STATE = S4;

endpackage

// File: rtl/moore_fsm_nol.sv
// Moore detector for serial pattern 1101, non-overlapping; out is high for one
// cycle after the edge that samples the final 1. No handshake, no backpressure.
module moore_fsm_nol
  import moore_fsm_nol_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  state_e r_state;
  state_e w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  // S4 never reuses matched bits; its sampled bit may only open a new match.
  always_comb begin
    w_next = S0;
    case (r_state)
      S0:      w_next = in ? S1 : S0;
      S1:      w_next = in ? S2 : S0;
      S2:      w_next = in ? S2 : S3;
      S3:      w_next = in ? S4 : S0;
      S4:      w_next = in ? S1 : S0;
      default: w_next = S0;
    endcase
  end

  assign out = (r_state == DETECT_STATE);

endmodule

// File: tb/tb_moore_fsm_nol.sv
// Randomized and directed checks of moore_fsm_nol against a bit-history model.
module tb_moore_fsm_nol;
  import moore_fsm_nol_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in;
  logic out;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Model: bits seen since the last detect (or reset); a detect consumes them all.
  logic [3:0] m_hist = 4'b0000;
  int         m_len  = 0;

  moore_fsm_nol dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_bit(input logic b, output logic e);
    m_hist = {m_hist[2:0], b};
    m_len++;
    if (m_len >= 4 && m_hist == 4'b1101) begin
      e     = 1'b1;
      m_len = 0;
    end else begin
      e = 1'b0;
    end
  endtask

  // Called just after a rising edge; drives one bit and checks out after the next edge.
  task automatic send(input logic b, input string tag);
    logic e;
    in = b;
    @(posedge clk);
    #1;
    model_bit(b, e);
    check_eq(tag, {31'd0, out}, {31'd0, e});
    if (out === 1'b1) pulses++;
  endtask

  task automatic run_seq(input logic [15:0] bits, input int n, input string tag, input int exp_pulses);
    pulses = 0;
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], tag);
    end
    check_eq({tag, "_pulses"}, pulses, exp_pulses);
    send(1'b0, {tag, "_tail"});
    check_eq({tag, "_tail_low"}, {31'd0, out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in  = 1'b0;

    for (int c = 0; c < 2; c++) begin
      in = ~in;
      @(posedge clk);
      #1;
      check_eq("rst_out", {31'd0, out}, 32'd0);
      check_eq("rst_state", {29'd0, dut.r_state}, {29'd0, S0});
    end
    rst   = 1'b0;
    m_len = 0;
    for (int c = 0; c < 3; c++) send(1'b0, "idle_after_rst");

    run_seq(16'b1101,      4, "basic",        1);
    run_seq(16'b1101101,   7, "non_overlap",  1);
    run_seq(16'b111101,    6, "prefix",       1);
    run_seq(16'b11011101,  8, "back_to_back", 2);

    send(1'b1, "mid_a");
    send(1'b1, "mid_b");
    send(1'b0, "mid_c");
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_state", {29'd0, dut.r_state}, {29'd0, S0});
    check_eq("async_out", {31'd0, out}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_len = 0;
    send(1'b1, "lone_one");
    send(1'b0, "lone_zero");
    send(1'b0, "lone_zero2");
    run_seq(16'b1101, 4, "after_async", 1);

    send(1'b1, "drop_a");
    send(1'b1, "drop_b");
    send(1'b0, "drop_c");
    send(1'b1, "drop_d");
    check_eq("drop_pulse_high", {31'd0, out}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("drop_async_out", {31'd0, out}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_len = 0;

    // Biased toward ones so the random stream contains real detects.
    for (int c = 0; c < 100; c++) begin
      send(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moore_fsm_nol.md
Name: moore_fsm_nol

Overview:
- Moore-type serial sequence detector for the bit pattern 1101, non-overlapping.
- Samples one input bit per rising clock edge.
- Asserts `out` for exactly one cycle while in the "pattern complete" state.
- Standalone leaf block for serial-stream pattern detection; no handshake and no data path.

Parameters:
- None. The pattern 1101 and the non-overlapping policy are fixed.

Ports:
- clk  input  1  rising-edge clock; the only clock domain.
- rst  input  1  asynchronous, active-high reset; forces the idle state immediately.
- in   input  1  serial data bit, sampled on each rising edge of clk.
- out  output 1  detect flag; 1 only while the FSM is in state S4.

Behaviour:
- Encoding: five states, held in a 3-bit state register.
  - S0 idle / nothing matched.
  - S1 seen "1".
  - S2 seen "11".
  - S3 seen "110".
  - S4 seen "1101", detect.
- Reset: while rst=1, state=S0 and out=0, independent of clk. Deassertion takes effect at the next rising edge.
- Transitions, evaluated at each rising edge with rst=0, in the form current: in=0 -> next; in=1 -> next:
  - S0: 0 -> S0; 1 -> S1.
  - S1: 0 -> S0; 1 -> S2.
  - S2: 0 -> S3; 1 -> S2 (the trailing "11" still counts as the prefix).
  - S3: 0 -> S0; 1 -> S4.
  - S4: 0 -> S0; 1 -> S1.
- S4 rule: the bits of the completed match are never reused. The bit sampled in S4 may start a new match.
- Output is Moore: out = (state == S4), decoded from the state register only, with no combinational path from `in`.
  - Latency: out rises on the clock edge that samples the final '1' of 1101. It stays high for exactly one cycle, then the FSM leaves S4.
- Illegal or unused encodings (values 5-7): next state is S0, out=0.
- Reset mid-sequence: partial progress is discarded and out drops to 0 asynchronously.
- Input timing: `in` must meet setup/hold around the rising edge of clk. Benches drive `in` away from the active edge, e.g. on the falling edge.
- No X propagation: out is driven 0 or 1 at all times after reset.

Decomposition:
- Shared package moore_fsm_nol_pkg:
  - state enum type (S0..S4, 3-bit);
  - constant DETECT_STATE = S4.
- One sequential process: async reset plus state register.
- One combinational next-state process.
- One continuous output decode.
- No sub-module; the block is a single leaf.

Test Plan:
- Reset: rst=1 for two cycles with in toggling -> state S0, out=0 throughout. After release with in=0 held -> out stays 0.
- Basic detect: in = 1,1,0,1 on four consecutive edges -> out=1 for exactly the cycle after the 4th edge, then 0 (next in=0).
- Non-overlap check: in = 1,1,0,1,1,0,1 -> exactly one out pulse, after bit 4. No pulse after bit 7; an overlapping design would give two.
- Prefix absorption: in = 1,1,1,1,0,1 -> single pulse after the final bit.
- Back-to-back patterns: in = 1,1,0,1,1,1,0,1 -> pulses after bit 4 and after bit 8, i.e. the bit sampled in S4 starts the next match.
- Async reset mid-match: drive 1,1,0, then assert rst between edges -> state S0 immediately. After release, a lone 1 gives no pulse; a full 1,1,0,1 gives one pulse.
- Random stream for 100 cycles against a reference model -> out matches exactly every cycle.
